// File: rtl/video_sequencer_if.sv
// Pixel-source handshake and synthesizer drive signals of the video sequencer.
interface video_sequencer_if;
    logic [5:0] pix_colour;
    logic [5:0] colour_num;
    logic [7:0] phase;
    logic       pix_req;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       line_start;
    logic       field_start;

    modport master (
        input  pix_colour,
        output colour_num,
        output phase,
        output pix_req,
        output pix_x,
        output pix_y,
        output line_start,
        output field_start
    );

    modport slave (
        output pix_colour,
        input  colour_num,
        input  phase,
        input  pix_req,
        input  pix_x,
        input  pix_y,
        input  line_start,
        input  field_start
    );
endinterface

// File: rtl/video_sequencer.sv
// Horizontal/vertical timing generator feeding colour codes and subcarrier phase
// to the composite synthesizer, fetching active pixels one cycle ahead.
module video_sequencer #(
    parameter int         LINE_LEN     = 910,
    parameter int         SYNC_LEN     = 67,
    parameter int         BURST_START  = 76,
    parameter int         BURST_LEN    = 36,
    parameter int         ACTIVE_START = 140,
    parameter int         ACTIVE_LEN   = 744,
    parameter int         FIELD_LINES  = 262,
    parameter int         VSYNC_LINES  = 3,
    parameter int         VBLANK_LINES = 20,
    parameter int         PHASE_STEP   = 64,
    parameter logic [5:0] SYNC_CODE    = 6'd0,
    parameter logic [5:0] BLANK_CODE   = 6'd1,
    parameter logic [5:0] BURST_CODE   = 6'd2
) (
    input  logic              clk,
    input  logic              reset,
    video_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        LINE_VSYNC,
        LINE_VBLANK,
        LINE_ACTIVE
    } lineType_t;

    localparam logic [9:0] H_LAST      = 10'(LINE_LEN - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(SYNC_LEN);
    localparam logic [9:0] H_VSYNC_END = 10'(LINE_LEN - SYNC_LEN);
    localparam logic [9:0] H_BURST_BEG = 10'(BURST_START);
    localparam logic [9:0] H_BURST_END = 10'(BURST_START + BURST_LEN);
    localparam logic [9:0] H_ACT_BEG   = 10'(ACTIVE_START);
    localparam logic [9:0] H_ACT_END   = 10'(ACTIVE_START + ACTIVE_LEN);
    localparam logic [9:0] H_REQ_BEG   = 10'(ACTIVE_START - 1);
    localparam logic [9:0] H_REQ_END   = 10'(ACTIVE_START - 1 + ACTIVE_LEN);
    localparam logic [8:0] V_LAST      = 9'(FIELD_LINES - 1);
    localparam logic [8:0] V_SYNC_END  = 9'(VSYNC_LINES);
    localparam logic [8:0] V_ACT_BEG   = 9'(VBLANK_LINES);
    localparam logic [7:0] PHASE_INC   = 8'(PHASE_STEP);

    logic [9:0] r_hCnt;
    logic [8:0] r_vCnt;
    logic [7:0] r_phase;
    logic [5:0] r_colourNum;
    logic       r_pixReq;
    logic [9:0] r_pixX;
    logic [8:0] r_pixY;
    logic       r_lineStart;
    logic       r_fieldStart;

    logic [9:0] w_hNext;
    logic [8:0] w_vNext;
    lineType_t  w_lineType;
    logic [5:0] w_colourNext;
    logic       w_pixReqNext;

    always_comb begin
        w_hNext = r_hCnt + 10'd1;
        w_vNext = r_vCnt;
        if (r_hCnt == H_LAST) begin
            w_hNext = '0;
            w_vNext = (r_vCnt == V_LAST) ? 9'd0 : r_vCnt + 9'd1;
        end
    end

    // Everything is decoded from the next count so registered outputs line up with h/v.
    always_comb begin
        w_lineType   = LINE_ACTIVE;
        w_colourNext = BLANK_CODE;
        w_pixReqNext = 1'b0;

        if (w_vNext < V_SYNC_END) begin
            w_lineType = LINE_VSYNC;
        end else if (w_vNext < V_ACT_BEG) begin
            w_lineType = LINE_VBLANK;
        end

        if (w_lineType == LINE_VSYNC) begin
            if (w_hNext < H_VSYNC_END) begin
                w_colourNext = SYNC_CODE;
            end
        end else if (w_hNext < H_SYNC_END) begin
            w_colourNext = SYNC_CODE;
        end else if ((w_lineType == LINE_ACTIVE) && (w_hNext >= H_ACT_BEG) && (w_hNext < H_ACT_END)) begin
            w_colourNext = bus.pix_colour;
        end else if ((w_hNext >= H_BURST_BEG) && (w_hNext < H_BURST_END)) begin
            w_colourNext = BURST_CODE;
        end

        if ((w_lineType == LINE_ACTIVE) && (w_hNext >= H_REQ_BEG) && (w_hNext < H_REQ_END)) begin
            w_pixReqNext = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hCnt       <= '0;
            r_vCnt       <= '0;
            r_phase      <= '0;
            r_colourNum  <= SYNC_CODE;
            r_pixReq     <= 1'b0;
            r_pixX       <= '0;
            r_pixY       <= '0;
            r_lineStart  <= 1'b1;
            r_fieldStart <= 1'b1;
        end else begin
            r_hCnt       <= w_hNext;
            r_vCnt       <= w_vNext;
            r_phase      <= r_phase + PHASE_INC;
            r_colourNum  <= w_colourNext;
            r_pixReq     <= w_pixReqNext;
            r_lineStart  <= (w_hNext == 10'd0);
            r_fieldStart <= (w_hNext == 10'd0) && (w_vNext == 9'd0);
            if (w_pixReqNext) begin
                r_pixX <= w_hNext - H_REQ_BEG;
                r_pixY <= w_vNext - V_ACT_BEG;
            end
        end
    end

    assign bus.colour_num  = r_colourNum;
    assign bus.phase       = r_phase;
    assign bus.pix_req     = r_pixReq;
    assign bus.pix_x       = r_pixX;
    assign bus.pix_y       = r_pixY;
    assign bus.line_start  = r_lineStart;
    assign bus.field_start = r_fieldStart;

endmodule

// File: doc/video_sequencer.md
Name: video_sequencer

Overview:
Timing controller that drives the composite video synthesizer's colour-code and subcarrier-phase inputs every sample clock. It generates horizontal and vertical timing: sync, blanking, colour burst and active video. It fetches active-video colour codes from a pixel source through a one-cycle request interface. Sits between the frame buffer/pixel generator and the synthesizer.

Parameters:
LINE_LEN, 910, samples per line (4x fsc at 14.318 MHz)
SYNC_LEN, 67, horizontal sync samples, h 0..66
BURST_START, 76, first burst sample
BURST_LEN, 36, burst samples (9 subcarrier cycles)
ACTIVE_START, 140, first active sample; must be >= 1
ACTIVE_LEN, 744, active samples per line; ACTIVE_START+ACTIVE_LEN <= LINE_LEN
FIELD_LINES, 262, lines per field
VSYNC_LINES, 3, lines 0..2 are vertical sync lines
VBLANK_LINES, 20, lines 0..19 carry no active video (includes vsync lines)
PHASE_STEP, 64, phase increment per sample (8-bit, modulo 256)
SYNC_CODE, 6'd0, colour code for sync tip
BLANK_CODE, 6'd1, colour code for blanking level
BURST_CODE, 6'd2, colour code for burst

Ports:
clk  in  1  sample clock
reset  in  1  asynchronous, active-high reset
pix_colour  in  6  colour code from pixel source, valid in the cycle pix_req is high
colour_num  out  6  colour code to synthesizer
phase  out  8  subcarrier phase to synthesizer
pix_req  out  1  pixel request
pix_x  out  10  requested pixel column, 0..ACTIVE_LEN-1
pix_y  out  9  requested pixel row, v_cnt-VBLANK_LINES
line_start  out  1  one-cycle strobe when h_cnt==0
field_start  out  1  one-cycle strobe when h_cnt==0 and v_cnt==0

Behaviour:
- One clock, clk. Reset is asynchronous and active-high. All state is in registers; all outputs are registered.
- Reset values: h_cnt=0, v_cnt=0, phase=0, colour_num=SYNC_CODE, pix_req=0, pix_x=0, pix_y=0, line_start=1, field_start=1. This is the first cycle of a field.
- Reset asserted mid-line or mid-field returns immediately to the reset state. On release, the field restarts at h=0, v=0 on the next edge.
- Counters:
  - h_cnt counts 0..LINE_LEN-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..FIELD_LINES-1 and wraps to 0.
- phase is free-running: phase <= phase + PHASE_STEP every cycle, 8-bit wrap. It is never reset at line or field boundaries.
- Outputs are aligned to the current h_cnt/v_cnt: registered from next-count decode, so colour_num at count (h,v) reflects segment(h,v).
- Line type is selected by v_cnt:
  - VSYNC (v < VSYNC_LINES): SYNC_CODE for h < LINE_LEN-SYNC_LEN, else BLANK_CODE. No burst. No pix_req.
  - VBLANK (VSYNC_LINES <= v < VBLANK_LINES): SYNC_CODE for h < SYNC_LEN; BURST_CODE for BURST_START <= h < BURST_START+BURST_LEN; BLANK_CODE otherwise. No pix_req.
  - ACTIVE (v >= VBLANK_LINES): same as VBLANK, except colour_num at ACTIVE_START <= h < ACTIVE_START+ACTIVE_LEN equals the fetched pixel.
- Pixel handshake (ACTIVE lines only):
  - pix_req=1 in cycles where h_cnt = ACTIVE_START-1+i, i = 0..ACTIVE_LEN-1, with pix_x=i and pix_y=v_cnt-VBLANK_LINES.
  - The source presents pix_colour in that same cycle.
  - The sequencer captures pix_colour at the clock edge, so colour_num = pix_colour at h_cnt = ACTIVE_START+i. Latency is one cycle.
  - pix_req is never held or stalled; the source must respond every requested cycle.
  - pix_x and pix_y hold their last value while pix_req=0.
- Priority for overlapping parameter windows: SYNC > ACTIVE > BURST > BLANK.
- Line wrap: at h_cnt=LINE_LEN-1 on the last active line, colour_num for the next cycle (h=0, next v) comes from the decode of the next line.
- Field wrap: v wraps from FIELD_LINES-1 to 0, and field_start pulses with line_start.

Test Plan:
- Reset release, defaults → colour_num=0 with field_start=1 at first cycle; colour_num stays 0 for h 0..842, then 1 for h 843..909 on v=0; phase sequence 0,64,128,192,0.
- Run to v=3 → colour_num=0 for h 0..66, 1 for h 67..75, 2 for h 76..111, 1 for h 112..909; no pix_req on v=3.
- v=20 with pix_colour = pix_x[5:0] → pix_req first high at h=139 (pix_x=0, pix_y=0) and last at h=882 (pix_x=743); colour_num at h=140+i equals i mod 64; colour_num=1 at h 884..909.
- Small parameters (LINE_LEN=20, FIELD_LINES=5, VSYNC_LINES=1, VBLANK_LINES=2) → line_start every 20 cycles; field_start every 100 cycles; v wraps 4→0; pix_y reaches 2 on v=4.
- Assert reset at v=50, h=300 for 3 cycles → outputs return to reset values while reset is high, asynchronously (checked mid-cycle); on release, counting restarts at h=0, v=0 and phase restarts at 0.
